// File: rtl/tree_acc_pkg.sv
// Shared types and default sizes for the tree ensemble accumulator.
// Default widths follow a 64-tree, 40-bit-accumulator configuration.
package tree_acc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResult
  } tree_acc_state_t;

  localparam int unsigned DEF_MAX_TREES      = 64;
  localparam int unsigned DEF_ACC_W          = 40;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
  localparam int unsigned LEAF_W             = 32;
  localparam int unsigned TREE_W             = $clog2(DEF_MAX_TREES);
  localparam int unsigned CNT_W              = $clog2(DEF_MAX_TREES + 1);

endpackage

// File: rtl/tree_acc_wdog.sv
// Per-tree watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT_CYCLES-th enabled cycle occurs.
module tree_acc_wdog
  import tree_acc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired = en && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/tree_ensemble_accum.sv
// Launches the tree engine once per tree and sums the signed leaf values.
// Define TREE_ACC_SATURATE_EN to clamp the sum instead of wrapping it.
module tree_ensemble_accum
  import tree_acc_pkg::*;
#(
  parameter int unsigned MAX_TREES      = DEF_MAX_TREES,
  parameter int unsigned ACC_W          = DEF_ACC_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [$clog2(MAX_TREES+1)-1:0] n_trees,
  output logic                           busy,
  output logic                           tree_start,
  output logic [$clog2(MAX_TREES)-1:0]   tree_index,
  input  logic                           tree_done,
  input  logic [LEAF_W-1:0]              leaf_value,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [ACC_W-1:0]               res_sum,
  output logic                           res_error,
  output logic                           res_sat
);

  localparam int unsigned IdxW = $clog2(MAX_TREES);
  localparam int unsigned CntW = $clog2(MAX_TREES + 1);

  tree_acc_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, n_clamp;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_add, leaf_ext;
  logic err_q, err_d, first_q, first_d;
  logic busy_q, tree_start_q, res_valid_q;
  logic run_clr, acc_en, wd_clr, wd_en, wd_expired, last_tree;

  assign n_clamp   = (n_trees > CntW'(MAX_TREES)) ? CntW'(MAX_TREES) : n_trees;
  assign last_tree = (CntW'(idx_q) == cnt_q - CntW'(1));
  assign leaf_ext  = {{(ACC_W - LEAF_W){leaf_value[LEAF_W-1]}}, leaf_value};

`ifdef TREE_ACC_SATURATE_EN
  logic [ACC_W:0] acc_wide;
  logic           sat_hit, sat_q;

  // One guard bit exposes signed overflow; clamp toward the overflow direction.
  assign acc_wide = {acc_q[ACC_W-1], acc_q} + {leaf_ext[ACC_W-1], leaf_ext};
  assign sat_hit  = acc_wide[ACC_W] != acc_wide[ACC_W-1];
  assign acc_add  = !sat_hit       ? acc_wide[ACC_W-1:0] :
                    acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                      {1'b0, {(ACC_W-1){1'b1}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (run_clr) begin
      sat_q <= 1'b0;
    end else if (acc_en && sat_hit) begin
      sat_q <= 1'b1;
    end
  end

  assign res_sat = sat_q;
`else
  assign acc_add = acc_q + leaf_ext;
  assign res_sat = 1'b0;
`endif

  tree_acc_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    err_d   = err_q;
    first_d = first_q;
    run_clr = 1'b0;
    acc_en  = 1'b0;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          run_clr = 1'b1;
          cnt_d   = n_clamp;
          idx_d   = '0;
          acc_d   = '0;
          err_d   = 1'b0;
          state_d = (n_clamp == '0) ? StResult : StLaunch;
        end
      end
      StLaunch: begin
        wd_clr  = 1'b1;
        first_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        wd_en   = 1'b1;
        first_d = 1'b0;
        // The first WAIT cycle may still see done from the previous traversal.
        if (tree_done && !first_q) begin
          acc_en = 1'b1;
          acc_d  = acc_add;
          if (last_tree) begin
            state_d = StResult;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StLaunch;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = StResult;
        end
      end
      StResult: begin
        if (res_valid_q && res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      err_q        <= 1'b0;
      first_q      <= 1'b0;
      busy_q       <= 1'b0;
      tree_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      err_q        <= err_d;
      first_q      <= first_d;
      busy_q       <= (state_d != StIdle);
      tree_start_q <= (state_d == StLaunch);
      res_valid_q  <= (state_d == StResult);
    end
  end

  assign busy       = busy_q;
  assign tree_start = tree_start_q;
  assign tree_index = idx_q;
  assign res_valid  = res_valid_q;
  assign res_sum    = acc_q;
  assign res_error  = err_q;

endmodule

// File: tb/tb_tree_ensemble_accum.sv
// Bench for tree_ensemble_accum with a behavioural tree engine and an
// ensemble-sum reference model; honours TREE_ACC_SATURATE_EN when defined.
module tb_tree_ensemble_accum;

  localparam int unsigned MT = 8;
  localparam int unsigned AW = 33;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  n_trees = '0;
  logic        busy, tree_start;
  logic [2:0]  tree_index;
  logic        tree_done;
  logic [31:0] leaf_value;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [32:0] res_sum;
  logic        res_error, res_sat;

  int errors = 0;
  int checks = 0;

  logic [31:0] leaf_tab [8];
  int          lat_tab [8];
  int          hang_idx = -1;
  int          launch_log [$];

  tree_ensemble_accum #(
    .MAX_TREES     (MT),
    .ACC_W         (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_trees   (n_trees),
    .busy      (busy),
    .tree_start(tree_start),
    .tree_index(tree_index),
    .tree_done (tree_done),
    .leaf_value(leaf_value),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_error (res_error),
    .res_sat   (res_sat)
  );

  always #5 clk = ~clk;

  // Engine: done drops two cycles after a launch (so a stale done overlaps the
  // masked cycle) and rises lat_tab[idx] cycles after the launch.
  initial begin
    int eng_cnt, eng_cur, eng_clr;
    bit eng_act;
    tree_done = 1'b0;
    leaf_value = '0;
    eng_act = 0;
    eng_clr = 0;
    eng_cnt = 0;
    eng_cur = 0;
    forever begin
      @(negedge clk);
      if (eng_clr > 0) begin
        eng_clr--;
        if (eng_clr == 0) tree_done = 1'b0;
      end
      if (tree_start) begin
        launch_log.push_back(int'(tree_index));
        eng_cur = int'(tree_index);
        eng_cnt = lat_tab[eng_cur];
        eng_act = 1;
        eng_clr = 2;
      end else if (eng_act) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_act = 0;
          if (eng_cur != hang_idx) begin
            tree_done = 1'b1;
            leaf_value = leaf_tab[eng_cur];
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input string what, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, exp);
    end
  endtask

  // Ensemble rules: clamp count, add each leaf in order, wrap or clamp to a
  // signed AW-bit range, stop with error at a tree that never finishes.
  function automatic void model(input int n, output logic [32:0] sum, output bit err,
                                output bit sat, output int ntr, output int cycles);
    longint s, maxv, minv, modv;
    int cnt;
    maxv = 64'sd4294967295;
    minv = -64'sd4294967296;
    modv = 64'sd8589934592;
    s = 0;
    err = 0;
    sat = 0;
    cycles = 0;
    cnt = (n > int'(MT)) ? int'(MT) : n;
    ntr = cnt;
    for (int i = 0; i < cnt; i++) begin
      cycles += 1;
      if (i == hang_idx) begin
        err = 1;
        cycles += TO;
        ntr = i + 1;
        break;
      end
      cycles += lat_tab[i];
      s += longint'($signed(leaf_tab[i]));
`ifdef TREE_ACC_SATURATE_EN
      if (s > maxv) begin s = maxv; sat = 1; end
      if (s < minv) begin s = minv; sat = 1; end
`else
      if (s > maxv) s -= modv;
      if (s < minv) s += modv;
`endif
    end
    sum = s[32:0];
  endfunction

  task automatic run(input string nm, input int n, input logic [32:0] es, input bit ee,
                     input bit esat);
    logic [32:0] ms;
    bit me, msat;
    int ntr, cyc, c, nl;
    model(n, ms, me, msat, ntr, cyc);
    launch_log.delete();
    @(negedge clk);
    start = 1'b1;
    n_trees = 4'(n);
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!res_valid && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk(nm, "valid", res_valid, 1);
    chk(nm, "cycles", c, cyc);
    chk(nm, "sum", res_sum, es);
    chk(nm, "error", res_error, ee);
    chk(nm, "sat", res_sat, esat);
    chk(nm, "busy", busy, 1);
    nl = launch_log.size();
    chk(nm, "launches", nl, ntr);
    for (int i = 0; i < nl; i++) chk(nm, "launch_idx", launch_log[i], i);
    chk(nm, "index_hold", tree_index, (ntr == 0) ? 0 : ntr - 1);
    repeat (2) @(negedge clk);
    chk(nm, "valid_held", res_valid, 1);
    chk(nm, "sum_held", res_sum, es);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk(nm, "valid_drop", res_valid, 0);
    chk(nm, "busy_drop", busy, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, "busy", busy, 0);
    chk(nm, "tree_start", tree_start, 0);
    chk(nm, "tree_index", tree_index, 0);
    chk(nm, "res_valid", res_valid, 0);
    chk(nm, "res_sum", res_sum, 0);
    chk(nm, "res_error", res_error, 0);
    chk(nm, "res_sat", res_sat, 0);
  endtask

  typedef struct {
    string       nm;
    int          n;
    int          hang;
    int          lat;
    logic [32:0] sum;
    bit          err;
    bit          sat;
  } vec_t;

  vec_t        tab [6];
  logic [31:0] leaf_row [6][8];

  initial begin
    logic [32:0] ms;
    bit me, msat;
    int ntr, cyc, c;

    for (int r = 0; r < 6; r++)
      for (int i = 0; i < 8; i++) leaf_row[r][i] = '0;
    tab[0] = '{"three", 3, -1, 5, 33'd13, 0, 0};
    leaf_row[0][0] = 32'd10;
    leaf_row[0][1] = -32'sd4;
    leaf_row[0][2] = 32'd7;
    tab[1] = '{"zero", 0, -1, 3, 33'd0, 0, 0};
    tab[2] = '{"stale", 2, -1, 3, 33'd300, 0, 0};
    leaf_row[2][0] = 32'd100;
    leaf_row[2][1] = 32'd200;
    tab[3] = '{"timeout", 2, 1, 4, 33'd5, 1, 0};
    leaf_row[3][0] = 32'd5;
`ifdef TREE_ACC_SATURATE_EN
    tab[4] = '{"overflow", 4, -1, 2, 33'h0_FFFF_FFFF, 0, 1};
`else
    tab[4] = '{"overflow", 4, -1, 2, 33'h1_FFFF_FFFC, 0, 0};
`endif
    for (int i = 0; i < 4; i++) leaf_row[4][i] = 32'h7FFF_FFFF;
    tab[5] = '{"clamp_n", 12, -1, 2, -33'sd3600, 0, 0};
    for (int i = 0; i < 8; i++) leaf_row[5][i] = -32'(100 * (i + 1));

    for (int i = 0; i < 8; i++) begin
      leaf_tab[i] = '0;
      lat_tab[i] = 3;
    end

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) begin
        leaf_tab[i] = leaf_row[r][i];
        lat_tab[i] = tab[r].lat;
      end
      hang_idx = tab[r].hang;
      run(tab[r].nm, tab[r].n, tab[r].sum, tab[r].err, tab[r].sat);
    end
    hang_idx = -1;

    // Reset while tree 2 is in flight, then a fresh single-tree run.
    for (int i = 0; i < 8; i++) begin
      leaf_tab[i] = 32'(i + 1);
      lat_tab[i] = 6;
    end
    launch_log.delete();
    @(negedge clk);
    start = 1'b1;
    n_trees = 4'd3;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (launch_log.size() < 3 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("midrst", "reached_tree2", launch_log.size(), 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    leaf_tab[0] = 32'd9;
    lat_tab[0] = 3;
    run("rerun", 1, 33'd9, 0, 0);

    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 8; i++) begin
        leaf_tab[i] = ($urandom_range(0, 2) == 0) ?
                      (($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000) :
                      32'($urandom);
        lat_tab[i] = int'($urandom_range(2, 7));
      end
      hang_idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
      c = int'($urandom_range(0, 15));
      model(c, ms, me, msat, ntr, cyc);
      run($sformatf("rand%0d", k), c, ms, me, msat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
